// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with replace-top, swap, occupancy
// flags, sticky overflow/underflow errors and a two-entry read port.
module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out_1st,
  output logic [WIDTH-1:0] data_out_2nd,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    sec_idx;
  logic             many;
  logic             op_push;
  logic             op_pop;
  logic             op_repl;
  logic             op_swap;
  logic             op_bad;
  logic             set_ovf;
  logic             set_unf;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign many    = (count > CNT_W'(1));
  assign wr_idx  = AW'(count);
  assign top_idx = AW'(count - CNT_W'(1));
  assign sec_idx = AW'(count - CNT_W'(2));

  assign op_bad  = swap & (push | pop);
  assign op_repl = push & pop & ~swap;
  assign op_push = push & ~pop & ~swap;
  assign op_pop  = pop & ~push & ~swap;
  assign op_swap = swap & ~push & ~pop;

  assign set_ovf = op_bad | (op_push & full);
  assign set_unf = op_bad
                 | (op_pop & empty)
                 | (op_swap & ~many);

  // Read port is gated by occupancy; storage is never cleared.
  assign data_out_1st = empty ? '0 : mem[top_idx];
  assign data_out_2nd = many ? mem[sec_idx] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err) | set_ovf;
      underflow <= (underflow & ~clr_err) | set_unf;
      unique case (1'b1)
        op_push: if (!full)  count <= count + CNT_W'(1);
        op_repl: if (empty)  count <= CNT_W'(1);
        op_pop:  if (!empty) count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Replace-top on an empty stack degenerates to a push at slot 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      unique case (1'b1)
        op_push: if (!full) mem[wr_idx] <= data_in;
        op_repl: mem[empty ? wr_idx : top_idx] <= data_in;
        op_swap: if (many) begin
          mem[top_idx] <= mem[sec_idx];
          mem[sec_idx] <= mem[top_idx];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: scoreboard bench for param_stack, a 32x4 instance
// for directed scenarios and an 8x5 instance for random traffic.
module tb_param_stack;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
  } snap_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        push, pop, swap, clr_err;
  logic [31:0] din;
  logic        sel;

  logic [31:0] a1, a2;
  logic [2:0]  acnt;
  logic        aemp, afull, aovf, aunf;
  logic [7:0]  b1, b2;
  logic [2:0]  bcnt;
  logic        bemp, bfull, bovf, bunf;

  logic [31:0] ms[$];
  logic        m_ovf, m_unf;
  snap_t       exp_q[$];
  snap_t       obs_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  param_stack #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) dut_a (
    .clock(clock), .reset(reset),
    .push(push & ~sel), .pop(pop & ~sel),
    .swap(swap & ~sel), .clr_err(clr_err & ~sel),
    .data_in(din),
    .data_out_1st(a1), .data_out_2nd(a2), .count(acnt),
    .empty(aemp), .full(afull),
    .overflow(aovf), .underflow(aunf)
  );

  param_stack #(.WIDTH(8), .DEPTH(5), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset),
    .push(push & sel), .pop(pop & sel),
    .swap(swap & sel), .clr_err(clr_err & sel),
    .data_in(din[7:0]),
    .data_out_1st(b1), .data_out_2nd(b2), .count(bcnt),
    .empty(bemp), .full(bfull),
    .overflow(bovf), .underflow(bunf)
  );

  function automatic snap_t model_snap();
    snap_t s;
    int n = ms.size();
    s.d1  = (n > 0) ? ms[n-1] : 32'h0;
    s.d2  = (n > 1) ? ms[n-2] : 32'h0;
    s.cnt = 3'(n);
    s.emp = (n == 0);
    s.ful = (n == (sel ? 5 : 4));
    s.ovf = m_ovf;
    s.unf = m_unf;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    if (sel) s = '{{24'h0, b1}, {24'h0, b2}, bcnt, bemp, bfull, bovf, bunf};
    else     s = '{a1, a2, acnt, aemp, afull, aovf, aunf};
    return s;
  endfunction

  // Drive one cycle, advance the reference stack, queue both snapshots.
  task automatic cyc(input logic p, input logic o, input logic s,
                     input logic c, input logic [31:0] d);
    logic so, su;
    logic [31:0] t, msk;
    int n, dep;
    msk = sel ? 32'hFF : 32'hFFFF_FFFF;
    dep = sel ? 5 : 4;
    push = p; pop = o; swap = s; clr_err = c; din = d;
    so = 1'b0; su = 1'b0;
    n = ms.size();
    if (s && (p || o)) begin
      so = 1'b1; su = 1'b1;
    end else if (p && o) begin
      if (n == 0) ms.push_back(d & msk);
      else ms[n-1] = d & msk;
    end else if (p) begin
      if (n == dep) so = 1'b1;
      else ms.push_back(d & msk);
    end else if (o) begin
      if (n == 0) su = 1'b1;
      else void'(ms.pop_back());
    end else if (s) begin
      if (n < 2) su = 1'b1;
      else begin
        t = ms[n-1]; ms[n-1] = ms[n-2]; ms[n-2] = t;
      end
    end
    m_ovf = (m_ovf & ~c) | so;
    m_unf = (m_unf & ~c) | su;
    exp_q.push_back(model_snap());
    @(posedge clock);
    #1;
    obs_q.push_back(dut_snap());
    push = 0; pop = 0; swap = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ms.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    n_chk++;
    if ({acnt, aemp, afull, aovf, aunf} !== 7'b000_1000) begin
      n_fail++;
      $display("FAIL reset_flags: got cnt=%0d e/f/o/u=%b%b%b%b want cnt=0 1000",
               acnt, aemp, afull, aovf, aunf);
    end
    n_chk++;
    if (a1 !== 32'h0 || a2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 0/0", a1, a2);
    end
  endtask

  task automatic test_push_pop();
    snap_t got, want;
    sel = 0;
    do_reset();
    cyc(1, 0, 0, 0, 32'hAAAA_0000);
    cyc(1, 0, 0, 0, 32'hBBBB_0000);
    cyc(1, 0, 0, 0, 32'hCCCC_0000);
    cyc(1, 0, 0, 0, 32'hDDDD_0000);
    n_chk++;
    if (a1 !== 32'hDDDD_0000 || a2 !== 32'hCCCC_0000 || acnt !== 3'd4) begin
      n_fail++;
      $display("FAIL push4: got %h/%h cnt=%0d want dddd0000/cccc0000 cnt=4",
               a1, a2, acnt);
    end
    repeat (5) cyc(0, 1, 0, 0, 32'h0);
    n_chk++;
    if (aunf !== 1'b1 || aemp !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_underflow: got unf=%b emp=%b want 1 1", aunf, aemp);
    end
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL push_pop: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  task automatic test_overflow();
    snap_t got, want;
    sel = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, 32'h1000 + i);
    n_chk++;
    if (afull !== 1'b1 || aovf !== 1'b1 || acnt !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow: got full=%b ovf=%b cnt=%0d want 1 1 4",
               afull, aovf, acnt);
    end
    cyc(0, 0, 0, 1, 32'h0);
    n_chk++;
    if (aovf !== 1'b0 || a1 !== 32'h1004) begin
      n_fail++;
      $display("FAIL clr_err: got ovf=%b top=%h want 0 00001004", aovf, a1);
    end
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL overflow_sb: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  task automatic test_replace();
    snap_t got, want;
    sel = 0;
    do_reset();
    cyc(1, 0, 0, 0, 32'hA);
    cyc(1, 0, 0, 0, 32'hB);
    cyc(1, 1, 0, 0, 32'hE);
    n_chk++;
    if (a1 !== 32'hE || a2 !== 32'hA || acnt !== 3'd2) begin
      n_fail++;
      $display("FAIL replace: got %h/%h cnt=%0d want e/a cnt=2", a1, a2, acnt);
    end
    cyc(1, 0, 0, 0, 32'hC);
    cyc(1, 0, 0, 0, 32'hD);
    cyc(1, 1, 0, 0, 32'hF);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h77);
    n_chk++;
    if (acnt !== 3'd1 || a1 !== 32'h77 || aunf !== 1'b0) begin
      n_fail++;
      $display("FAIL replace_empty: got cnt=%0d top=%h unf=%b want 1 77 0",
               acnt, a1, aunf);
    end
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL replace_sb: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  task automatic test_swap();
    snap_t got, want;
    sel = 0;
    do_reset();
    cyc(1, 0, 0, 0, 32'h11);
    cyc(1, 0, 0, 0, 32'hA);
    cyc(1, 0, 0, 0, 32'hB);
    cyc(0, 0, 1, 0, 32'h0);
    n_chk++;
    if (a1 !== 32'hA || a2 !== 32'hB) begin
      n_fail++;
      $display("FAIL swap: got %h/%h want a/b", a1, a2);
    end
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    n_chk++;
    if (aunf !== 1'b1 || a1 !== 32'h11 || acnt !== 3'd1) begin
      n_fail++;
      $display("FAIL swap_short: got unf=%b top=%h cnt=%0d want 1 11 1",
               aunf, a1, acnt);
    end
    cyc(0, 0, 0, 1, 32'h0);
    cyc(1, 0, 0, 0, 32'h22);
    cyc(1, 0, 1, 0, 32'h99);
    n_chk++;
    if ({aovf, aunf} !== 2'b11 || a1 !== 32'h22 || acnt !== 3'd2) begin
      n_fail++;
      $display("FAIL swap_push: got o/u=%b%b top=%h cnt=%0d want 11 22 2",
               aovf, aunf, a1, acnt);
    end
    cyc(0, 1, 1, 0, 32'h0);
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL swap_sb: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  task automatic test_async_reset();
    sel = 0;
    do_reset();
    cyc(1, 0, 0, 0, 32'h1);
    cyc(1, 0, 0, 0, 32'h2);
    cyc(1, 0, 0, 0, 32'h3);
    exp_q.delete();
    obs_q.delete();
    push = 1; din = 32'h4;
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (acnt !== 3'd0 || a1 !== 32'h0 || a2 !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d %h/%h want 0 0/0", acnt, a1, a2);
    end
    @(posedge clock);
    #1;
    n_chk++;
    if (acnt !== 3'd0 || aemp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_blocks_push: got cnt=%0d emp=%b want 0 1", acnt, aemp);
    end
    push = 0;
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    ms.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_err_priority();
    snap_t got, want;
    sel = 0;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 32'h50 + i);
    cyc(1, 0, 0, 1, 32'h60);
    n_chk++;
    if (aovf !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clr: got ovf=%b want 1", aovf);
    end
    cyc(0, 0, 0, 1, 32'h0);
    cyc(1, 1, 0, 0, 32'h61);
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL err_sb: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  task automatic test_random();
    snap_t got, want;
    int r;
    sel = 1;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 19);
      cyc(r < 7 || r == 16 || r == 18,
          (r >= 7 && r < 13) || r == 16 || r == 19,
          (r >= 13 && r < 16) || r >= 18,
          ($urandom_range(0, 7) == 0),
          $urandom);
    end
    while (exp_q.size() != 0) begin
      want = exp_q.pop_front(); got = obs_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random: got %h/%h c%0d %b want %h/%h c%0d %b",
                 got.d1, got.d2, got.cnt, {got.emp, got.ful, got.ovf, got.unf},
                 want.d1, want.d2, want.cnt, {want.emp, want.ful, want.ovf, want.unf});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    push = 0; pop = 0; swap = 0; clr_err = 0;
    din = 32'h0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #12;
    test_reset();
    test_push_pop();
    test_overflow();
    test_replace();
    test_swap();
    test_async_reset();
    test_err_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
